md_sequencer: RTL and testbench

//  Multi-cycle multiply/divide sequencer in the EX stage. Consumes the MD

---
 rtl/md_sequencer.sv | 103 ++++++++++
 tb/tb_md_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle multiply/divide sequencer that owns HI/LO and stalls HI/LO consumers.
// Operands are latched at start so the EX-stage sources may change while the op runs.
module md_sequencer #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic             MDE,
    input  logic             MDSignE,
    input  logic             HLWriteE,
    input  logic             HLSelE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             Cancel,
    input  logic             NeedMDD,
    output logic             StallMD,
    output logic             BusyE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

    state_t             state, nextState;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   opA, opB;
    logic               opSign, start, done, negA, negB;
    logic [2*WIDTH-1:0] extA, extB, product;
    logic [WIDTH-1:0]   magA, magB, uQuot, uRem, quot, rem, resHi, resLo;

    assign start = state == IDLE && StartE && !Cancel;
    assign done  = state != IDLE && count == '0 && !Cancel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = Cancel ? IDLE : start ? (MDE ? DIV : MULT) : done ? IDLE : state;
    end

    always_comb begin
        BusyE   = state != IDLE;
        StallMD = NeedMDD & (BusyE | StartE);
    end

    // Sign-extending to 2*WIDTH lets one truncated multiply serve both signednesses.
    always_comb begin
        extA    = opSign ? {{WIDTH{opA[WIDTH-1]}}, opA} : {{WIDTH{1'b0}}, opA};
        extB    = opSign ? {{WIDTH{opB[WIDTH-1]}}, opB} : {{WIDTH{1'b0}}, opB};
        product = extA * extB;
        negA    = opSign & opA[WIDTH-1];
        negB    = opSign & opB[WIDTH-1];
        magA    = negA ? -opA : opA;
        magB    = negB ? -opB : opB;
        uQuot   = magA / magB;
        uRem    = magA % magB;
        quot    = (negA ^ negB) ? -uQuot : uQuot;
        rem     = negA ? -uRem : uRem;
        resHi   = state == MULT ? product[2*WIDTH-1:WIDTH] : opB == '0 ? opA : rem;
        resLo   = state == MULT ? product[WIDTH-1:0] : opB == '0 ? '1 : quot;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            opA    <= '0;
            opB    <= '0;
            opSign <= 1'b0;
        end else if (start) begin
            count  <= MDE ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            opA    <= SrcAE;
            opB    <= SrcBE;
            opSign <= MDSignE;
        end else if (Cancel) begin
            count  <= '0;
        end else if (state != IDLE && count != '0) begin
            count  <= count - CW'(1);
        end
    end

    // A completing op overrides any mthi/mtlo landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= '0;
            LO <= '0;
        end else if (done) begin
            HI <= resHi;
            LO <= resLo;
        end else if (HLWriteE && !Cancel) begin
            if (HLSelE) HI <= SrcAE;
            else        LO <= SrcAE;
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !(BusyE && StartE));
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed vectors, corner sequences and random traffic against a cycle-count reference model.
module tb_md_sequencer;
    localparam int MC = 5, DC = 10;

    logic        clk = 0, reset = 0, StartE = 0, MDE = 0, MDSignE = 0, HLWriteE = 0, HLSelE = 0;
    logic        Cancel = 0, NeedMDD = 0;
    logic [31:0] SrcAE = 0, SrcBE = 0;
    logic        StallMD, BusyE;
    logic [31:0] HI, LO;

    md_sequencer #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .StartE(StartE), .MDE(MDE), .MDSignE(MDSignE),
        .HLWriteE(HLWriteE), .HLSelE(HLSelE), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .Cancel(Cancel), .NeedMDD(NeedMDD), .StallMD(StallMD), .BusyE(BusyE),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        md, sign;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t        vt[9];
    int          nCmp = 0, nBad = 0;
    int          remain = 0;
    logic [31:0] mHi = 0, mLo = 0, pHi = 0, pLo = 0;

    function automatic logic [63:0] mdRef(input logic md, input logic sign, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (!md) return sign ? 64'(sa * sb) : 64'(ua * ub);
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (sign) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare mid-cycle against the model, then advance the model across the edge.
    task automatic tick();
        @(negedge clk);
        check("StallMD", {31'd0, StallMD}, {31'd0, NeedMDD & (remain > 0 || StartE)});
        check("BusyE", {31'd0, BusyE}, {31'd0, remain > 0});
        check("HI", HI, mHi);
        check("LO", LO, mLo);
        if (HLWriteE && !Cancel) begin
            if (HLSelE) mHi = SrcAE;
            else        mLo = SrcAE;
        end
        if (Cancel) remain = 0;
        else if (remain > 0) begin
            remain--;
            if (remain == 0) {mHi, mLo} = {pHi, pLo};
        end else if (StartE) begin
            remain = MDE ? DC : MC;
            {pHi, pLo} = mdRef(MDE, MDSignE, SrcAE, SrcBE);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runVec(input int i);
        int n;
        StartE = 1; MDE = vt[i].md; MDSignE = vt[i].sign; SrcAE = vt[i].a; SrcBE = vt[i].b; NeedMDD = 1;
        tick();
        StartE = 0; SrcAE = $urandom; SrcBE = $urandom; MDSignE = ~MDSignE;
        n = 0;
        while (BusyE && n < 30) begin
            n++;
            tick();
        end
        check($sformatf("busyLen[%0d]", i), n, vt[i].md ? DC : MC);
        check($sformatf("vecHI[%0d]", i), HI, vt[i].hi);
        check($sformatf("vecLO[%0d]", i), LO, vt[i].lo);
        tick();
        NeedMDD = 0;
    endtask

    initial begin
        logic [31:0] sHi, sLo;
        vt[0] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vt[1] = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[2] = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vt[3] = '{1'b1, 1'b0, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vt[4] = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vt[5] = '{1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14};
        vt[6] = '{1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vt[7] = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vt[8] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};

        #2;
        check("rstBusy", {31'd0, BusyE}, 32'd0);
        check("rstHI", HI, 32'd0);
        check("rstLO", LO, 32'd0);
        @(posedge clk);
        #1;
        reset = 1;

        for (int i = 0; i < 9; i++) runVec(i);

        // Cancel at t+4 of a divide: back to idle, HI/LO untouched.
        sHi = HI; sLo = LO;
        StartE = 1; MDE = 1; MDSignE = 0; SrcAE = 32'd500; SrcBE = 32'd3;
        tick();
        StartE = 0;
        repeat (3) tick();
        Cancel = 1;
        tick();
        Cancel = 0;
        check("cancelBusy", {31'd0, BusyE}, 32'd0);
        check("cancelHI", HI, sHi);
        check("cancelLO", LO, sLo);
        StartE = 1; Cancel = 1;
        tick();
        StartE = 0; Cancel = 0;
        check("startCancelBusy", {31'd0, BusyE}, 32'd0);

        // mthi in idle, then mtlo squashed by Cancel.
        sLo = LO;
        HLWriteE = 1; HLSelE = 1; SrcAE = 32'h1234;
        tick();
        check("mthiHI", HI, 32'h1234);
        check("mthiLO", LO, sLo);
        HLSelE = 0; Cancel = 1; SrcAE = 32'hDEAD;
        tick();
        HLWriteE = 0; Cancel = 0;
        check("mtloCancelLO", LO, sLo);
        check("mtloCancelHI", HI, 32'h1234);

        // Asynchronous reset at t+3 of a multiply.
        StartE = 1; MDE = 0; MDSignE = 0; SrcAE = 32'd9; SrcBE = 32'd9;
        tick();
        StartE = 0;
        repeat (2) tick();
        reset = 0;
        #1;
        check("asyncRstBusy", {31'd0, BusyE}, 32'd0);
        check("asyncRstHI", HI, 32'd0);
        check("asyncRstLO", LO, 32'd0);
        remain = 0; mHi = 0; mLo = 0;
        tick();
        reset = 1;
        runVec(0);

        for (int c = 0; c < 400; c++) begin
            StartE   = remain == 0 && ($urandom % 4 == 0);
            MDE      = 1'($urandom);
            MDSignE  = 1'($urandom);
            HLWriteE = $urandom % 6 == 0;
            HLSelE   = 1'($urandom);
            Cancel   = $urandom % 12 == 0;
            NeedMDD  = 1'($urandom);
            case ($urandom % 5)
                0:       SrcAE = 32'h80000000;
                1:       SrcAE = $urandom % 16;
                default: SrcAE = $urandom;
            endcase
            case ($urandom % 5)
                0:       SrcBE = 32'd0;
                1:       SrcBE = 32'hFFFFFFFF;
                2:       SrcBE = $urandom % 16;
                default: SrcBE = $urandom;
            endcase
            tick();
        end
        StartE = 0; HLWriteE = 0; Cancel = 0; NeedMDD = 0;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
